// File: rtl/pulse_mod_pkg.sv
// Shared constants for the servo pulse modulator: default timing, frame count,
// ModInfo field layout and the magnitude split helper.
package pulse_mod_pkg;

  localparam int PULSE_W_DEF = 21;
  localparam int NEUTRAL_DEF = 150000;
  localparam int STEP_DEF    = 10000;
  localparam int FRAME_COUNT = 24;

  localparam int MOD_DIR_BIT  = 4;
  localparam int MOD_MAG_MSB  = 3;
  localparam int MOD_MAG_LSB  = 0;

  typedef struct packed {
    logic [2:0] q;
    logic [1:0] r;
  } mag_split_t;

  // Divide-by-3 by threshold comparison; magnitude is only 0..15.
  function automatic mag_split_t split_mag(input logic [3:0] m);
    mag_split_t s;
    logic [3:0] rem;
    if (m >= 4'd15)      s.q = 3'd5;
    else if (m >= 4'd12) s.q = 3'd4;
    else if (m >= 4'd9)  s.q = 3'd3;
    else if (m >= 4'd6)  s.q = 3'd2;
    else if (m >= 4'd3)  s.q = 3'd1;
    else                 s.q = 3'd0;
    rem = m - ({1'b0, s.q} + {s.q, 1'b0});
    s.r = rem[1:0];
    return s;
  endfunction

endpackage

// File: rtl/pulse_mod_dither.sv
// Extra-step generator: spreads the magnitude remainder across the 24-frame
// cycle so the mean pulse resolves thirds of a STEP.
module pulse_mod_dither
  import pulse_mod_pkg::*;
(
  input  logic [4:0] state,
  input  logic [1:0] r,
  output logic       extra
);

  logic [1:0] state_mod3;

  always_comb begin
    state_mod3 = 2'd2;
    case (state)
      5'd0, 5'd3, 5'd6, 5'd9, 5'd12, 5'd15, 5'd18, 5'd21, 5'd24, 5'd27, 5'd30:
        state_mod3 = 2'd0;
      5'd1, 5'd4, 5'd7, 5'd10, 5'd13, 5'd16, 5'd19, 5'd22, 5'd25, 5'd28, 5'd31:
        state_mod3 = 2'd1;
      default:
        state_mod3 = 2'd2;
    endcase
  end

  assign extra = (state < 5'(FRAME_COUNT)) && (state_mod3 < r);

endmodule

// File: rtl/pulse_modulation.sv
// Servo pulse-width command for one motor channel, registered one cycle after
// ModInfo/State. Frame dithering is enabled by defining PULSE_MOD_DITHER_EN.
module pulse_modulation
  import pulse_mod_pkg::*;
#(
  parameter int PULSE_W = PULSE_W_DEF,
  parameter int NEUTRAL = NEUTRAL_DEF,
  parameter int STEP    = STEP_DEF,
  parameter int INVERT  = 0
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [4:0]         ModInfo,
  input  logic [4:0]         State,
  output logic [PULSE_W-1:0] Pulse
);

`ifdef PULSE_MOD_DITHER_EN
  localparam logic DITHER_EN = 1'b1;
`else
  localparam logic DITHER_EN = 1'b0;
`endif

  mag_split_t         split;
  logic               dir;
  logic               dither_extra;
  logic               extra;
  logic [3:0]         steps;
  logic [PULSE_W-1:0] offset;
  logic [PULSE_W-1:0] pulse_next;

  assign split = split_mag(ModInfo[MOD_MAG_MSB:MOD_MAG_LSB]);
  assign dir   = ModInfo[MOD_DIR_BIT] ^ (INVERT != 0);

  pulse_mod_dither u_dither (
    .state (State),
    .r     (split.r),
    .extra (dither_extra)
  );

  // With dithering compiled out the extra step is tied low and State drops away.
  assign extra = DITHER_EN & dither_extra;

  always_comb begin
    steps      = {1'b0, split.q} + {3'd0, extra};
    offset     = PULSE_W'(steps) * PULSE_W'(STEP);
    pulse_next = dir ? (PULSE_W'(NEUTRAL) + offset) : (PULSE_W'(NEUTRAL) - offset);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) Pulse <= PULSE_W'(NEUTRAL);
    else     Pulse <= pulse_next;
  end

endmodule

// File: tb/tb_pulse_modulation.sv
// Directed bench for pulse_modulation: left channel (INVERT=0) and right
// channel (INVERT=1) driven from the same command inputs.
module tb_pulse_modulation;

`ifdef PULSE_MOD_DITHER_EN
  localparam bit DITHER = 1'b1;
`else
  localparam bit DITHER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mod_info;
  logic [4:0]  state;
  logic [20:0] pulse_left;
  logic [20:0] pulse_right;

  int tests = 0;
  int fails = 0;
  logic [20:0] exp_q[$];

  always #5 clk = ~clk;

  pulse_modulation u_left (
    .CLK(clk), .RST(rst), .ModInfo(mod_info), .State(state), .Pulse(pulse_left)
  );

  pulse_modulation #(.INVERT(1)) u_right (
    .CLK(clk), .RST(rst), .ModInfo(mod_info), .State(state), .Pulse(pulse_right)
  );

  typedef struct {
    string       name;
    logic [4:0]  mod_info;
    logic [4:0]  state;
    logic [20:0] exp_dither;
    logic [20:0] exp_plain;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply(input logic [4:0] mi, input logic [4:0] st);
    @(negedge clk);
    mod_info = mi;
    state    = st;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sum;
    logic [20:0] e;

    // Reset: output neutral immediately, with a full-forward command waiting.
    rst      = 1'b1;
    mod_info = 5'b1_1111;
    state    = 5'd0;
    #1;
    check("reset_async_left", pulse_left, 21'd150000);
    check("reset_async_right", pulse_right, 21'd150000);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held_clocked", pulse_left, 21'd150000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("release_first_edge_left", pulse_left, 21'd200000);
    check("release_first_edge_right", pulse_right, 21'd100000);

    // Reassert mid-cycle: must clear without a clock edge.
    #2 rst = 1'b1;
    #1;
    check("reset_midcycle", pulse_left, 21'd150000);
    @(negedge clk);
    rst = 1'b0;

    vecs.push_back('{"full_fwd",      5'b1_1111, 5'd0,  21'd200000, 21'd200000});
    vecs.push_back('{"full_rev",      5'b0_1111, 5'd7,  21'd100000, 21'd100000});
    vecs.push_back('{"zero_fwd",      5'b1_0000, 5'd5,  21'd150000, 21'd150000});
    vecs.push_back('{"zero_rev",      5'b0_0000, 5'd20, 21'd150000, 21'd150000});
    vecs.push_back('{"m4_s0",         5'b1_0100, 5'd0,  21'd170000, 21'd160000});
    vecs.push_back('{"m4_s1",         5'b1_0100, 5'd1,  21'd160000, 21'd160000});
    vecs.push_back('{"m4_s3",         5'b1_0100, 5'd3,  21'd170000, 21'd160000});
    vecs.push_back('{"m4_s21",        5'b1_0100, 5'd21, 21'd170000, 21'd160000});
    vecs.push_back('{"m4_s23",        5'b1_0100, 5'd23, 21'd160000, 21'd160000});
    vecs.push_back('{"m4_s24_oor",    5'b1_0100, 5'd24, 21'd160000, 21'd160000});
    vecs.push_back('{"m8_s0",         5'b0_1000, 5'd0,  21'd120000, 21'd130000});
    vecs.push_back('{"m8_s1",         5'b0_1000, 5'd1,  21'd120000, 21'd130000});
    vecs.push_back('{"m8_s2",         5'b0_1000, 5'd2,  21'd130000, 21'd130000});
    vecs.push_back('{"m8_s22",        5'b0_1000, 5'd22, 21'd120000, 21'd130000});
    vecs.push_back('{"m8_s25_oor",    5'b0_1000, 5'd25, 21'd130000, 21'd130000});
    vecs.push_back('{"m8_s30_oor",    5'b0_1000, 5'd30, 21'd130000, 21'd130000});
    vecs.push_back('{"m7_fwd_s0",     5'b1_0111, 5'd0,  21'd180000, 21'd170000});
    vecs.push_back('{"m14_rev_s1",    5'b0_1110, 5'd1,  21'd100000, 21'd110000});
    vecs.push_back('{"m14_rev_s2",    5'b0_1110, 5'd2,  21'd110000, 21'd110000});

    // Back-to-back vectors also cover a command change taking effect next cycle.
    foreach (vecs[i]) begin
      apply(vecs[i].mod_info, vecs[i].state);
      check(vecs[i].name, pulse_left, DITHER ? vecs[i].exp_dither : vecs[i].exp_plain);
    end

    // Mirror-mounted channel: direction bit reversed.
    apply(5'b1_0011, 5'd4);
    check("invert_fwd_right", pulse_right, 21'd140000);
    check("invert_fwd_left", pulse_left, 21'd160000);
    apply(5'b0_0011, 5'd9);
    check("invert_rev_right", pulse_right, 21'd160000);
    check("invert_rev_left", pulse_left, 21'd140000);

    // Full 24-frame sweep at M=4 forward: per-frame values and the mean.
    sum = 0;
    for (int s = 0; s < 24; s++) begin
      e = (DITHER && (s % 3 == 0)) ? 21'd170000 : 21'd160000;
      exp_q.push_back(e);
      apply(5'b1_0100, 5'(s));
      check($sformatf("sweep_m4_s%0d", s), pulse_left, exp_q.pop_front());
      sum += int'(pulse_left);
    end
    tests++;
    if (sum != (DITHER ? 3920000 : 3840000)) begin
      fails++;
      $display("FAIL sweep_m4_sum: got %0d expected %0d", sum, DITHER ? 3920000 : 3840000);
    end

    // Sweep at M=8 reverse: mean must be 150000 - 80000/3 with dithering.
    sum = 0;
    for (int s = 0; s < 24; s++) begin
      apply(5'b0_1000, 5'(s));
      sum += int'(pulse_left);
    end
    tests++;
    if (sum != (DITHER ? 2960000 : 3120000)) begin
      fails++;
      $display("FAIL sweep_m8_sum: got %0d expected %0d", sum, DITHER ? 2960000 : 3120000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pulse_modulation.md
PULSE_MODULATION -- requirements
Module: pulse_modulation

Interface
REQ-001 Parameter PULSE_W, default 21, width of Pulse in clock ticks.
REQ-002 Parameter NEUTRAL, default 150000, neutral pulse width in ticks (1.5 ms at 100 MHz).
REQ-003 Parameter STEP, default 10000, coarse pulse increment in ticks (0.1 ms).
REQ-004 Parameter INVERT, default 0; 1 = direction bit reversed (mirror-mounted motor).
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 CLK  input  1  system clock, all state on rising edge.
REQ-007 RST  input  1  asynchronous active-high reset.
REQ-008 ModInfo  input  5  motor command: bit 4 direction (1 = forward), bits 3:0 magnitude M (0..15).
REQ-009 State  input  5  frame index 0..23 supplied by the pulse sequencer, advances once per 11 ms frame.
REQ-010 Pulse  output  PULSE_W  commanded high-time in ticks for the current frame.

Function
REQ-011 Pulse SHALL be registered; it reflects ModInfo/State sampled on the previous rising CLK edge (latency 1 cycle).
REQ-012 Effective direction D = ModInfo[4] XOR INVERT; D = 1 adds offset, D = 0 subtracts it.
REQ-013 Magnitude SHALL split as q = M / 3 (0..5) and r = M mod 3 (0..2), both unsigned.
REQ-014 Extra step E = 1 when State <= 23 and (State mod 3) < r, else E = 0.
REQ-015 Offset = (q + E) * STEP; Pulse = NEUTRAL + Offset if D = 1, NEUTRAL - Offset if D = 0.
REQ-016 Average Pulse over States 0..23 SHALL equal NEUTRAL +/- M*STEP/3 exactly (24 divisible by 3).
REQ-017 M = 0 SHALL give Pulse = NEUTRAL regardless of direction and State.
REQ-018 Pulse range SHALL be NEUTRAL +/- 5*STEP (100000..200000 at defaults); no overflow or wrap in PULSE_W bits.
REQ-019 State values 24..31 are out of range: E = 0, Pulse = NEUTRAL +/- q*STEP.
REQ-020 ModInfo changing mid-frame SHALL take effect on the next cycle; no frame-boundary holding inside this block.
REQ-021 Arithmetic: q, r via constant lookup or comparison (no general divider); result width PULSE_W, unsigned.

Reset
REQ-022 While RST = 1, Pulse SHALL be NEUTRAL immediately (asynchronous), independent of CLK.
REQ-023 After RST deasserts, the first rising CLK edge loads the REQ-015 value.

Configuration
REQ-024 Macro PULSE_MOD_DITHER_EN defined: E computed per REQ-014.
REQ-025 Macro PULSE_MOD_DITHER_EN undefined: E forced to 0, Pulse = NEUTRAL +/- q*STEP, State ignored.

Structure
REQ-026 Package pulse_mod_pkg holds NEUTRAL, STEP, PULSE_W defaults, frame count 24, and the 5-bit ModInfo field positions.
REQ-027 One sub-module, pulse_mod_dither, SHALL compute E from State and r; the top holds direction, offset arithmetic and output register.
REQ-028 Left and right motor channels SHALL be two instances of pulse_modulation (right with INVERT as required by mounting).

Verification
REQ-029 RST = 1 with any ModInfo -> Pulse = 150000; release, ModInfo = 5'b1_1111 -> Pulse = 200000 on next edge.
REQ-030 ModInfo = 5'b0_1111, any State -> 100000; ModInfo = 5'b1_0000 and 5'b0_0000 -> 150000.
REQ-031 Dither on, ModInfo = 5'b1_0100 (q=1, r=1): State 0,3,...,21 -> 170000; other states -> 160000; 24-frame mean 163333.33.
REQ-032 Dither on, ModInfo = 5'b0_1000 (q=2, r=2): State mod 3 in {0,1} -> 120000; State mod 3 = 2 -> 130000; State = 25 -> 130000.
REQ-033 INVERT = 1, ModInfo = 5'b1_0011 -> 140000; ModInfo = 5'b0_0011 -> 160000.
REQ-034 Macro undefined, ModInfo = 5'b1_0100, sweep State 0..23 -> 160000 constant.
